slurm16_mem_arbiter: RTL and testbench

Shares the single slurm16 memory port between two requesters:
- the CPU pipeline (port 0, high priority);
- a DMA / boot-loader master (port 1).

It sits between the requesters and memory_controller. It drives ADDRESS, write data, OEb and WRb, and returns read data tagged to the winning requester. Arbitration is fixed-priority with a starvation guard and a bounded DMA burst lock.

---
 rtl/slurm16_pkg.sv | 31 +++
 rtl/slurm16_mem_arbiter_if.sv | 25 ++
 rtl/slurm16_arb_pick.sv | 60 ++++++
 rtl/slurm16_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_slurm16_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slurm16_pkg.sv
// -----------------------------------------------------------------------------
// slurm16_pkg
// Shared types and default sizes for the slurm16 memory arbiter.
//   owner_t      : which requester a memory access belongs to.
//   arb_state_t  : arbiter state (last grant and whether a DMA burst is open).
//   cnt_width()  : width of a counter that must hold 0..max_val.
// -----------------------------------------------------------------------------
package slurm16_pkg;

  localparam int BITS_DEF         = 16;
  localparam int ADDRESS_BITS_DEF = 16;
  localparam int STARVE_MAX_DEF   = 4;
  localparam int MAX_BURST_DEF    = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CPU   = 2'd1,
    DMA   = 2'd2,
    BURST = 2'd3
  } arb_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/slurm16_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// slurm16_mem_arbiter_if
// One requester's access bus into the arbiter.
//   req/wr/addr/wdata : access request, held until gnt is seen.
//   gnt               : one-cycle pulse, access issued to memory.
//   rvalid/rdata      : read return, one-cycle pulse.
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface slurm16_mem_arbiter_if
  import slurm16_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int BITS         = BITS_DEF
);
  logic                    req;
  logic                    wr;
  logic [ADDRESS_BITS-1:0] addr;
  logic [BITS-1:0]         wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [BITS-1:0]         rdata;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/slurm16_arb_pick.sv
// -----------------------------------------------------------------------------
// slurm16_arb_pick
// Combinational grant decision for the memory arbiter.
//   Inputs : cpu_req, dma_req, dma_lock, current state, starve_cnt, burst_cnt.
//   Outputs: grant_cpu, grant_dma (mutually exclusive), next_state.
// CPU has fixed priority; DMA wins a contested cycle when it has been starved
// STARVE_MAX cycles, or while an open burst is still under MAX_BURST grants.
// -----------------------------------------------------------------------------
module slurm16_arb_pick
  import slurm16_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int SW         = cnt_width(STARVE_MAX),
  parameter int BW         = cnt_width(MAX_BURST)
)(
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  arb_state_t    state,
  input  logic [SW-1:0] starve_cnt,
  input  logic [BW-1:0] burst_cnt,
  output logic          grant_cpu,
  output logic          grant_dma,
  output arb_state_t    next_state
);

  logic dma_priority;
  logic burst_capped;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    next_state = IDLE;

    dma_priority = (starve_cnt == SW'(STARVE_MAX)) ||
                   ((state == BURST) && (burst_cnt < BW'(MAX_BURST)) && dma_lock);
    burst_capped = (state == BURST) && dma_lock && (burst_cnt >= BW'(MAX_BURST));

    if (cpu_req && dma_req) begin
      if (dma_priority) begin
        grant_dma  = 1'b1;
        next_state = dma_lock ? BURST : DMA;
      end else begin
        grant_cpu  = 1'b1;
        // A capped burst yields exactly one slot to the CPU; staying in BURST
        // (with burst_cnt cleared) lets the still-locked burst resume next cycle.
        next_state = burst_capped ? BURST : CPU;
      end
    end else if (cpu_req) begin
      grant_cpu  = 1'b1;
      next_state = CPU;
    end else if (dma_req) begin
      grant_dma  = 1'b1;
      next_state = dma_lock ? BURST : DMA;
    end
  end

endmodule

// File: rtl/slurm16_mem_arbiter.sv
// -----------------------------------------------------------------------------
// slurm16_mem_arbiter
// Shares the single slurm16 memory port between the CPU (port 0, high
// priority) and a DMA / boot-loader master (port 1).
// Ports:
//   CLK, RST            : clock, synchronous active-high reset.
//   cpu, dma            : requester buses (slurm16_mem_arbiter_if.slave).
//   dma_lock            : DMA asks for back-to-back grants (burst).
//   mem_address/mem_wdata/mem_OEb/mem_WRb : registered memory_controller drive.
//   mem_rdata           : read data, valid one cycle after mem_OEb low.
// Optional (SLURM16_ARB_STATS_EN defined): cpu_grants, dma_grants,
//   dma_stall_cycles, 16-bit wrapping counters.
// Timing: request seen in cycle N -> gnt + strobe in N+1 -> rvalid in N+2.
// -----------------------------------------------------------------------------
module slurm16_mem_arbiter
  import slurm16_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int BITS         = BITS_DEF,
  parameter int STARVE_MAX   = STARVE_MAX_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF
)(
  input  logic                    CLK,
  input  logic                    RST,
  slurm16_mem_arbiter_if.slave    cpu,
  slurm16_mem_arbiter_if.slave    dma,
  input  logic                    dma_lock,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [BITS-1:0]         mem_wdata,
  input  logic [BITS-1:0]         mem_rdata,
  output logic                    mem_OEb,
  output logic                    mem_WRb
`ifdef SLURM16_ARB_STATS_EN
  ,
  output logic [15:0]             cpu_grants,
  output logic [15:0]             dma_grants,
  output logic [15:0]             dma_stall_cycles
`endif
);

  localparam int SW = cnt_width(STARVE_MAX);
  localparam int BW = cnt_width(MAX_BURST);

  arb_state_t              state;
  arb_state_t              next_state;
  logic [SW-1:0]           starve_cnt;
  logic [BW-1:0]           burst_cnt;
  logic                    grant_cpu;
  logic                    grant_dma;
  logic                    grant_any;
  logic                    sel_wr;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [BITS-1:0]         sel_wdata;
  logic                    rd_pending;
  owner_t                  rd_owner;

  slurm16_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .MAX_BURST  (MAX_BURST),
    .SW         (SW),
    .BW         (BW)
  ) u_pick (
    .cpu_req    (cpu.req),
    .dma_req    (dma.req),
    .dma_lock   (dma_lock),
    .state      (state),
    .starve_cnt (starve_cnt),
    .burst_cnt  (burst_cnt),
    .grant_cpu  (grant_cpu),
    .grant_dma  (grant_dma),
    .next_state (next_state)
  );

  // Mux the winning requester's access onto the memory side.
  always_comb begin
    grant_any = grant_cpu | grant_dma;
    sel_wr    = grant_dma ? dma.wr    : cpu.wr;
    sel_addr  = grant_dma ? dma.addr  : cpu.addr;
    sel_wdata = grant_dma ? dma.wdata : cpu.wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // Clearing rd_pending here is what drops the return of an aborted read.
      state       <= IDLE;
      starve_cnt  <= '0;
      burst_cnt   <= '0;
      cpu.gnt     <= 1'b0;
      dma.gnt     <= 1'b0;
      cpu.rvalid  <= 1'b0;
      dma.rvalid  <= 1'b0;
      cpu.rdata   <= '0;
      dma.rdata   <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_OEb     <= 1'b1;
      mem_WRb     <= 1'b1;
      rd_pending  <= 1'b0;
      rd_owner    <= OWN_CPU;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= next_state;
      cpu.gnt <= grant_cpu;
      dma.gnt <= grant_dma;

      // Strobes are exclusive by construction: at most one grant, one direction.
      mem_OEb <= !(grant_any && !sel_wr);
      mem_WRb <= !(grant_any &&  sel_wr);
      if (grant_any) begin
        mem_address <= sel_addr;
        mem_wdata   <= sel_wdata;
      end

      // Owner tag travels with the strobe; data is captured one cycle later.
      rd_pending <= grant_any && !sel_wr;
      rd_owner   <= grant_dma ? OWN_DMA : OWN_CPU;

      cpu.rvalid <= rd_pending && (rd_owner == OWN_CPU);
      dma.rvalid <= rd_pending && (rd_owner == OWN_DMA);
      if (rd_pending && (rd_owner == OWN_CPU)) cpu.rdata <= mem_rdata;
      if (rd_pending && (rd_owner == OWN_DMA)) dma.rdata <= mem_rdata;

      // Starvation: consecutive lost DMA cycles, saturating, cleared by a win.
      if (grant_dma) begin
        starve_cnt <= '0;
      end else if (dma.req && (starve_cnt != SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      // Burst length: counts DMA grants inside BURST; anything else clears it,
      // including the single CPU slot taken when the burst hits MAX_BURST.
      if (grant_dma && (next_state == BURST)) begin
        if (state != BURST) begin
          burst_cnt <= BW'(1);
        end else if (burst_cnt != BW'(MAX_BURST)) begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

`ifdef SLURM16_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cpu_grants       <= '0;
      dma_grants       <= '0;
      dma_stall_cycles <= '0;
    end else begin
      cpu_grants       <= cpu_grants + 16'(grant_cpu);
      dma_grants       <= dma_grants + 16'(grant_dma);
      dma_stall_cycles <= dma_stall_cycles + 16'(dma.req && !grant_dma);
    end
  end
`endif

endmodule

// File: tb/tb_slurm16_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_slurm16_mem_arbiter
// Directed bench for slurm16_mem_arbiter (STARVE_MAX = 4, MAX_BURST = 8).
// Memory model: address 0x1234 holds 0xBEEF, every other address holds ~addr.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_slurm16_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dma_lock = 1'b0;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_OEb;
  logic        mem_WRb;
`ifdef SLURM16_ARB_STATS_EN
  logic [15:0] cpu_grants;
  logic [15:0] dma_grants;
  logic [15:0] dma_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  slurm16_mem_arbiter_if cpu_bus ();
  slurm16_mem_arbiter_if dma_bus ();

  slurm16_mem_arbiter #(
    .ADDRESS_BITS (16),
    .BITS         (16),
    .STARVE_MAX   (4),
    .MAX_BURST    (8)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .cpu         (cpu_bus),
    .dma         (dma_bus),
    .dma_lock    (dma_lock),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_OEb     (mem_OEb),
    .mem_WRb     (mem_WRb)
`ifdef SLURM16_ARB_STATS_EN
    ,
    .cpu_grants       (cpu_grants),
    .dma_grants       (dma_grants),
    .dma_stall_cycles (dma_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : ~a;
  endfunction

  assign mem_rdata = mem_OEb ? 16'h0000 : mem_model(mem_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_bus.req = 1'b0; cpu_bus.wr = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
    dma_bus.req = 1'b0; dma_bus.wr = 1'b0; dma_bus.addr = '0; dma_bus.wdata = '0;
    dma_lock    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Stress bookkeeping
  logic        p_cpu_req, p_dma_req, p_cpu_wr, p_dma_wr;
  logic [15:0] p_cpu_addr, p_dma_addr;
  logic        exp_cpu_rv, exp_dma_rv;
  logic [15:0] exp_cpu_data, exp_dma_data;
  int          viol_excl, viol_gnt, viol_rv;

  initial begin
    idle_inputs();

    // ---------------- reset values ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_oeb",    mem_OEb, 1);
    check("rst_wrb",    mem_WRb, 1);
    check("rst_addr",   mem_address, 0);
    check("rst_wdata",  mem_wdata, 0);
    check("rst_cgnt",   cpu_bus.gnt, 0);
    check("rst_dgnt",   dma_bus.gnt, 0);
    check("rst_crv",    cpu_bus.rvalid, 0);
    check("rst_drv",    dma_bus.rvalid, 0);
    check("rst_crdata", cpu_bus.rdata, 0);
    check("rst_drdata", dma_bus.rdata, 0);

    // ---------------- CPU read 0x1234 ----------------
    @(posedge clk); #1;
    cpu_bus.req = 1'b1; cpu_bus.wr = 1'b0; cpu_bus.addr = 16'h1234;
    @(posedge clk); #1;
    cpu_bus.req = 1'b0;
    @(negedge clk);
    check("rd_cgnt", cpu_bus.gnt, 1);
    check("rd_dgnt", dma_bus.gnt, 0);
    check("rd_oeb",  mem_OEb, 0);
    check("rd_wrb",  mem_WRb, 1);
    check("rd_addr", mem_address, 16'h1234);
    @(negedge clk);
    check("rd_crv",    cpu_bus.rvalid, 1);
    check("rd_crdata", cpu_bus.rdata, 16'hBEEF);
    check("rd_drv",    dma_bus.rvalid, 0);
    check("rd_gnt_pulse", cpu_bus.gnt, 0);
    @(negedge clk);
    check("rd_rv_pulse", cpu_bus.rvalid, 0);

    // ---------------- DMA write 0x0010 <- 0xA5A5 ----------------
    @(posedge clk); #1;
    dma_bus.req = 1'b1; dma_bus.wr = 1'b1; dma_bus.addr = 16'h0010; dma_bus.wdata = 16'hA5A5;
    @(posedge clk); #1;
    dma_bus.req = 1'b0;
    @(negedge clk);
    check("wr_dgnt",  dma_bus.gnt, 1);
    check("wr_cgnt",  cpu_bus.gnt, 0);
    check("wr_wrb",   mem_WRb, 0);
    check("wr_oeb",   mem_OEb, 1);
    check("wr_addr",  mem_address, 16'h0010);
    check("wr_wdata", mem_wdata, 16'hA5A5);
    @(negedge clk);
    check("wr_drv",      dma_bus.rvalid, 0);
    check("wr_crv",      cpu_bus.rvalid, 0);
    check("wr_wrb_pulse", mem_WRb, 1);
    idle_inputs();

    // ---------------- starvation: 4 CPU then 1 DMA ----------------
    repeat (3) @(posedge clk);
    #1;
    cpu_bus.req = 1'b1; cpu_bus.wr = 1'b0; cpu_bus.addr = 16'h0100;
    dma_bus.req = 1'b1; dma_bus.wr = 1'b0; dma_bus.addr = 16'h0200;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("starve_cgnt_%0d", i), cpu_bus.gnt, (i % 5) != 4);
      check($sformatf("starve_dgnt_%0d", i), dma_bus.gnt, (i % 5) == 4);
      if (i > 0) check($sformatf("starve_drv_%0d", i), dma_bus.rvalid, ((i - 1) % 5) == 4);
      if (i == 5) check("starve_drdata", dma_bus.rdata, 16'hFDFF);
    end
    idle_inputs();

    // ---------------- burst cap: 8 DMA, 1 CPU, repeat ----------------
    repeat (3) @(posedge clk);
    #1;
    cpu_bus.req = 1'b1; cpu_bus.wr = 1'b0; cpu_bus.addr = 16'h0300;
    dma_bus.req = 1'b1; dma_bus.wr = 1'b0; dma_bus.addr = 16'h0400;
    dma_lock    = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      logic exp_dma;
      exp_dma = (i >= 4) && (((i - 4) % 9) != 8);
      @(negedge clk);
      check($sformatf("burst_dgnt_%0d", i), dma_bus.gnt, exp_dma);
      check($sformatf("burst_cgnt_%0d", i), cpu_bus.gnt, !exp_dma);
    end
    idle_inputs();

    // ---------------- reset in the cycle after a CPU read grant ----------------
    repeat (3) @(posedge clk);
    #1;
    cpu_bus.req = 1'b1; cpu_bus.wr = 1'b0; cpu_bus.addr = 16'h1234;
    @(posedge clk); #1;
    cpu_bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_cgnt", cpu_bus.gnt, 1);
    check("rstrd_oeb",  mem_OEb, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrd_crv",    cpu_bus.rvalid, 0);
    check("rstrd_oeb2",   mem_OEb, 1);
    check("rstrd_wrb",    mem_WRb, 1);
    check("rstrd_addr",   mem_address, 0);
    check("rstrd_wdata",  mem_wdata, 0);
    check("rstrd_cgnt2",  cpu_bus.gnt, 0);
    check("rstrd_crdata", cpu_bus.rdata, 0);
    check("rstrd_drdata", dma_bus.rdata, 0);
    @(negedge clk);
    check("rstrd_crv_late", cpu_bus.rvalid, 0);

    // ---------------- random stress ----------------
    viol_excl = 0; viol_gnt = 0; viol_rv = 0;
    exp_cpu_rv = 1'b0; exp_dma_rv = 1'b0;
    exp_cpu_data = '0; exp_dma_data = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      p_cpu_req = cpu_bus.req; p_cpu_wr = cpu_bus.wr; p_cpu_addr = cpu_bus.addr;
      p_dma_req = dma_bus.req; p_dma_wr = dma_bus.wr; p_dma_addr = dma_bus.addr;
      cpu_bus.req   = 1'($urandom_range(0, 1));
      cpu_bus.wr    = 1'($urandom_range(0, 1));
      cpu_bus.addr  = 16'($urandom);
      cpu_bus.wdata = 16'($urandom);
      dma_bus.req   = 1'($urandom_range(0, 1));
      dma_bus.wr    = 1'($urandom_range(0, 1));
      dma_bus.addr  = 16'($urandom);
      dma_bus.wdata = 16'($urandom);
      dma_lock      = ($urandom_range(0, 9) < 4);
      @(negedge clk);
      if (!mem_OEb && !mem_WRb) viol_excl++;
      if (cpu_bus.gnt && dma_bus.gnt) viol_excl++;
      if (!((cpu_bus.gnt && p_cpu_req && !dma_bus.gnt) ||
            (dma_bus.gnt && p_dma_req && !cpu_bus.gnt) ||
            (!cpu_bus.gnt && !dma_bus.gnt && !p_cpu_req && !p_dma_req))) viol_gnt++;
      if (cpu_bus.gnt && ((mem_OEb !== p_cpu_wr) || (mem_address !== p_cpu_addr))) viol_gnt++;
      if (dma_bus.gnt && ((mem_OEb !== p_dma_wr) || (mem_address !== p_dma_addr))) viol_gnt++;
      if (cpu_bus.rvalid !== exp_cpu_rv) viol_rv++;
      if (dma_bus.rvalid !== exp_dma_rv) viol_rv++;
      if (exp_cpu_rv && (cpu_bus.rdata !== exp_cpu_data)) viol_rv++;
      if (exp_dma_rv && (dma_bus.rdata !== exp_dma_data)) viol_rv++;
      exp_cpu_rv   = cpu_bus.gnt && !p_cpu_wr;
      exp_dma_rv   = dma_bus.gnt && !p_dma_wr;
      exp_cpu_data = mem_model(p_cpu_addr);
      exp_dma_data = mem_model(p_dma_addr);
    end
    idle_inputs();
    check("stress_excl", viol_excl, 0);
    check("stress_gnt",  viol_gnt, 0);
    check("stress_rv",   viol_rv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
